qspi_sram_sync: RTL and testbench

- Parametrised, clk-synchronous successor to the fixed QSPI SRAM model used in the simulation top.
- Oversamples sck, ss_n and sio with the system clock, so the memory model and the DUT share one clock and one reset.
- Supports SPI and QPI modes, mode-switch commands, fast read with configurable dummy cycles, configurable depth and address wrap.
- Sits beside tt_um_levenshtein in sim; connects through the uio pins exactly like the previous model.

---
 rtl/qspi_pkg.sv | 20 ++
 rtl/sync_edge_detect.sv | 37 +++
 rtl/qspi_sram_sync.sv | 180 ++++++++++++++++++
 tb/tb_qspi_sram_sync.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// Shared opcodes and FSM state encoding for the clk-synchronous QSPI SRAM model.
package qspi_pkg;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] CMD_WRITE     = 8'h02;
    localparam logic [7:0] CMD_ENTER_QPI = 8'h38;
    localparam logic [7:0] CMD_EXIT_QPI  = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        READ,
        WRITE,
        IGNORE
    } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for one asynchronous pin, followed by registered rise/fall pulses.
module sync_edge_detect #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic r_p0;
    logic r_p1;
    logic r_prev;
    logic r_rise;
    logic r_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p0   <= RST_VAL;
            r_p1   <= RST_VAL;
            r_prev <= RST_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_p0   <= i_sig;
            r_p1   <= r_p0;
            r_prev <= r_p1;
            r_rise <= r_p1 & ~r_prev;
            r_fall <= ~r_p1 & r_prev;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/qspi_sram_sync.sv
// QSPI/QPI SRAM model that oversamples sck, ss_n and sio with the system clock.
// Commands: read (0x03), fast read (0x0B), write (0x02), enter/exit QPI (0x38/0xFF).
module qspi_sram_sync
    import qspi_pkg::*;
#(
    parameter int ADDR_BITS = 24,
    parameter int DEPTH     = 65536,
    parameter int SPI_DUMMY = 8,
    parameter int QPI_DUMMY = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       ss_n,
    input  logic [3:0] sio_in,
    output logic [3:0] sio_out,
    output logic [3:0] sio_oe,
    output logic       quad_mode
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        return (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
    endfunction

    logic w_sck_rise, w_sck_fall, w_ss_rise, w_ss_fall;
    logic [3:0] r_sio_p0, r_sio_p1;

    sync_edge_detect #(.RST_VAL(1'b0)) u_sck (
        .clk(clk), .rst(rst), .i_sig(sck), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );

    sync_edge_detect #(.RST_VAL(1'b1)) u_ss (
        .clk(clk), .rst(rst), .i_sig(ss_n), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );

    // sio is two flops only: edge pulses lag one clk more, data is stable for half an sck period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sio_p0 <= '0;
            r_sio_p1 <= '0;
        end else begin
            r_sio_p0 <= sio_in;
            r_sio_p1 <= r_sio_p0;
        end
    end

    state_e               r_state;
    logic                 r_sel, r_quad, r_wr_en;
    logic [3:0]           r_sio_out, r_sio_oe;
    logic [7:0]           r_cnt, r_cmd, r_op, r_byte, r_rd_sh, r_wr_data;
    logic [ADDR_BITS-1:0] r_addr_sh;
    logic [AW-1:0]        r_addr, r_wr_addr;
    logic [7:0]           r_mem [DEPTH];

    logic [7:0]           w_cmd_next, w_byte_next, w_rd_byte, w_rd_src, w_dummy;
    logic [ADDR_BITS-1:0] w_addr_next;
    logic                 w_last_byte, w_last_addr;

    assign w_cmd_next  = r_quad ? {r_cmd[3:0], r_sio_p1} : {r_cmd[6:0], r_sio_p1[0]};
    assign w_byte_next = r_quad ? {r_byte[3:0], r_sio_p1} : {r_byte[6:0], r_sio_p1[0]};
    assign w_addr_next = r_quad ? {r_addr_sh[ADDR_BITS-5:0], r_sio_p1}
                                : {r_addr_sh[ADDR_BITS-2:0], r_sio_p1[0]};
    assign w_last_byte = (r_cnt == (r_quad ? 8'd1 : 8'd7));
    assign w_last_addr = (r_cnt == (r_quad ? 8'(ADDR_BITS / 4 - 1) : 8'(ADDR_BITS - 1)));
    assign w_dummy     = r_quad ? 8'(QPI_DUMMY) : 8'(SPI_DUMMY);
    assign w_rd_byte   = r_mem[r_addr];
    assign w_rd_src    = (r_cnt == 8'd0) ? w_rd_byte : r_rd_sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sel     <= 1'b0;
            r_quad    <= 1'b0;
            r_sio_out <= '0;
            r_sio_oe  <= '0;
            r_cnt     <= '0;
            r_cmd     <= '0;
            r_op      <= '0;
            r_byte    <= '0;
            r_rd_sh   <= '0;
            r_addr_sh <= '0;
            r_addr    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_ss_rise) begin
                r_sel     <= 1'b0;
                r_state   <= IDLE;
                r_sio_oe  <= '0;
                r_sio_out <= '0;
                r_cnt     <= '0;
            end else if (w_ss_fall) begin
                // an sck rise landing in the same clk is the first command bit
                r_sel   <= 1'b1;
                r_state <= CMD;
                r_cnt   <= w_sck_rise ? 8'd1 : 8'd0;
                if (w_sck_rise) r_cmd <= w_cmd_next;
            end else if (r_sel) begin
                case (r_state)
                    CMD: if (w_sck_rise) begin
                        r_cmd <= w_cmd_next;
                        r_cnt <= r_cnt + 8'd1;
                        if (w_last_byte) begin
                            r_cnt <= '0;
                            r_op  <= w_cmd_next;
                            case (w_cmd_next)
                                CMD_READ:                 r_state <= r_quad ? IGNORE : ADDR;
                                CMD_FAST_READ, CMD_WRITE: r_state <= ADDR;
                                CMD_ENTER_QPI: begin r_quad <= 1'b1; r_state <= IGNORE; end
                                CMD_EXIT_QPI:  begin r_quad <= 1'b0; r_state <= IGNORE; end
                                default:                  r_state <= IGNORE;
                            endcase
                        end
                    end
                    ADDR: if (w_sck_rise) begin
                        r_addr_sh <= w_addr_next;
                        r_cnt     <= r_cnt + 8'd1;
                        if (w_last_addr) begin
                            r_cnt  <= '0;
                            r_addr <= AW'(w_addr_next % DEPTH);
                            if (r_op == CMD_WRITE)                               r_state <= WRITE;
                            else if (r_op == CMD_FAST_READ && w_dummy != 8'd0) r_state <= DUMMY;
                            else                                                 r_state <= READ;
                        end
                    end
                    DUMMY: if (w_sck_rise) begin
                        if (r_cnt == w_dummy - 8'd1) begin
                            r_cnt   <= '0;
                            r_state <= READ;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    READ: if (w_sck_fall) begin
                        if (r_quad) begin
                            r_sio_oe  <= 4'b1111;
                            r_sio_out <= w_rd_src[7:4];
                            r_rd_sh   <= {w_rd_src[3:0], 4'b0000};
                        end else begin
                            r_sio_oe  <= 4'b0010;
                            r_sio_out <= {2'b00, w_rd_src[7], 1'b0};
                            r_rd_sh   <= {w_rd_src[6:0], 1'b0};
                        end
                        r_cnt <= r_cnt + 8'd1;
                        if (w_last_byte) begin
                            r_cnt  <= '0;
                            r_addr <= addr_inc(r_addr);
                        end
                    end
                    WRITE: if (w_sck_rise) begin
                        r_byte <= w_byte_next;
                        r_cnt  <= r_cnt + 8'd1;
                        if (w_last_byte) begin
                            r_cnt     <= '0;
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_addr;
                            r_wr_data <= w_byte_next;
                            r_addr    <= addr_inc(r_addr);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // storage survives reset
    always_ff @(posedge clk) begin
        if (r_wr_en) r_mem[r_wr_addr] <= r_wr_data;
    end

    assign sio_out   = r_sio_out;
    assign sio_oe    = r_sio_oe;
    assign quad_mode = r_quad;

endmodule

// File: tb/tb_qspi_sram_sync.sv
// Directed bench for qspi_sram_sync: an SPI/QPI master task set plus a read-data scoreboard.
module tb_qspi_sram_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic       sck;
    logic       ss_n;
    logic [3:0] sio_in;
    logic [3:0] sio_out;
    logic [3:0] sio_oe;
    logic       quad_mode;

    int checks = 0;
    int errors = 0;
    int oe_cnt = 0;
    int snap;

    logic [11:0] exp_q [$];
    logic [11:0] mon_exp;
    logic [7:0]  mon_sh = 8'h00;
    logic [3:0]  mon_oe = 4'h0;
    int          mon_bits = 0;

    qspi_sram_sync #(.DEPTH(256)) dut (
        .clk(clk), .rst(rst), .sck(sck), .ss_n(ss_n),
        .sio_in(sio_in), .sio_out(sio_out), .sio_oe(sio_oe), .quad_mode(quad_mode)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sio_oe != 4'b0000) oe_cnt++;
    end

    // master samples on sck rise; each completed byte is scored against the queue
    always @(posedge sck or posedge ss_n) begin
        if (ss_n) begin
            mon_bits = 0;
        end else if (sio_oe != 4'b0000) begin
            if (mon_bits == 0) mon_oe = sio_oe;
            if (sio_oe == 4'b1111) begin
                mon_sh = {mon_sh[3:0], sio_out};
                mon_bits += 4;
            end else begin
                mon_sh = {mon_sh[6:0], sio_out[1]};
                mon_bits += 1;
            end
            if (mon_bits >= 8) begin
                mon_bits = 0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_extra got %02h oe %b, nothing expected", mon_sh, mon_oe);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({mon_sh, mon_oe} !== mon_exp) begin
                        errors++;
                        $display("FAIL rd_byte got %02h oe %b want %02h oe %b",
                                 mon_sh, mon_oe, mon_exp[11:4], mon_exp[3:0]);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic cyc(input logic [3:0] d);
        sio_in = d;
        #50 sck = 1'b1;
        #50 sck = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit quad, input int nbits);
        if (quad) begin
            for (int i = 1; i >= 0; i--) cyc(b[i*4 +: 4]);
        end else begin
            for (int i = 7; i >= 8 - nbits; i--) cyc({3'b000, b[i]});
        end
    endtask

    task automatic send_addr(input logic [23:0] a, input bit quad);
        send(a[23:16], quad, 8);
        send(a[15:8], quad, 8);
        send(a[7:0], quad, 8);
    endtask

    task automatic start();
        ss_n = 1'b0;
        #50;
    endtask

    task automatic stop();
        #50 ss_n = 1'b1;
        #200;
    endtask

    task automatic expect_rd(input logic [7:0] b, input bit quad);
        exp_q.push_back({b, quad ? 4'b1111 : 4'b0010});
    endtask

    task automatic read(input int nbytes, input bit quad);
        repeat (nbytes * (quad ? 2 : 8)) cyc(4'b0000);
    endtask

    task automatic cmd_frame(input logic [7:0] op, input bit quad);
        start();
        send(op, quad, 8);
        stop();
    endtask

    initial begin
        rst = 1'b1; sck = 1'b0; ss_n = 1'b1; sio_in = 4'h0;
        #22;
        chk("rst_quad", 32'(quad_mode), 32'h0);
        chk("rst_oe", 32'(sio_oe), 32'h0);
        chk("rst_out", 32'(sio_out), 32'h0);
        #30 rst = 1'b0;
        #100;

        // SPI write 0xA5 0x3C at 0x10, read back
        start(); send(8'h02, 0, 8); send_addr(24'h000010, 0);
        send(8'hA5, 0, 8); send(8'h3C, 0, 8); stop();
        expect_rd(8'hA5, 0); expect_rd(8'h3C, 0);
        start(); send(8'h03, 0, 8); send_addr(24'h000010, 0); read(2, 0); stop();

        // partial write byte at 0x20 is dropped
        start(); send(8'h02, 0, 8); send_addr(24'h000020, 0); send(8'h5A, 0, 8); stop();
        start(); send(8'h02, 0, 8); send_addr(24'h000020, 0); send(8'hF0, 0, 4); stop();
        expect_rd(8'h5A, 0);
        start(); send(8'h03, 0, 8); send_addr(24'h000020, 0); read(1, 0); stop();

        // abort a read mid-byte
        start(); send(8'h03, 0, 8); send_addr(24'h000010, 0);
        repeat (4) cyc(4'h0);
        chk("oe_mid_read", 32'(sio_oe), 32'h2);
        #50 ss_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("oe_after_abort", 32'(sio_oe), 32'h0);
        #198;

        // unknown opcode in SPI
        snap = oe_cnt;
        start(); send(8'h9F, 0, 8); send_addr(24'h000000, 0); stop();
        chk("unk_oe_cycles", 32'(oe_cnt - snap), 32'h0);
        chk("unk_quad", 32'(quad_mode), 32'h0);

        // enter QPI, then enter again while already in QPI
        cmd_frame(8'h38, 0);
        chk("enter_qpi", 32'(quad_mode), 32'h1);
        cmd_frame(8'h38, 1);
        chk("enter_qpi_again", 32'(quad_mode), 32'h1);

        // QPI fast read of the SPI-written bytes
        expect_rd(8'hA5, 1); expect_rd(8'h3C, 1);
        start(); send(8'h0B, 1, 8); send_addr(24'h000010, 1);
        repeat (6) cyc(4'h0); read(2, 1); stop();

        // 0x03 is not accepted in QPI
        snap = oe_cnt;
        start(); send(8'h03, 1, 8); send_addr(24'h000010, 1); repeat (8) cyc(4'h0); stop();
        chk("qpi_read03_oe_cycles", 32'(oe_cnt - snap), 32'h0);
        chk("qpi_read03_quad", 32'(quad_mode), 32'h1);

        // write across the top of a 256-byte memory
        start(); send(8'h02, 1, 8); send_addr(24'h0000FF, 1);
        send(8'h11, 1, 8); send(8'h22, 1, 8); stop();
        expect_rd(8'h11, 1); expect_rd(8'h22, 1);
        start(); send(8'h0B, 1, 8); send_addr(24'h0000FF, 1);
        repeat (6) cyc(4'h0); read(2, 1); stop();
        expect_rd(8'h22, 1);
        start(); send(8'h0B, 1, 8); send_addr(24'h000000, 1);
        repeat (6) cyc(4'h0); read(1, 1); stop();
        expect_rd(8'hA5, 1);
        start(); send(8'h0B, 1, 8); send_addr(24'h000110, 1);
        repeat (6) cyc(4'h0); read(1, 1); stop();

        // exit QPI, exit again in SPI, re-enter
        cmd_frame(8'hFF, 1);
        chk("exit_qpi", 32'(quad_mode), 32'h0);
        cmd_frame(8'hFF, 0);
        chk("exit_qpi_again", 32'(quad_mode), 32'h0);
        cmd_frame(8'h38, 0);
        chk("reenter_qpi", 32'(quad_mode), 32'h1);

        // reset in the middle of a QPI read; memory survives
        start(); send(8'h0B, 1, 8); send_addr(24'h000010, 1);
        repeat (6) cyc(4'h0); cyc(4'h0);
        chk("oe_qpi_read", 32'(sio_oe), 32'hF);
        rst = 1'b1;
        #1;
        chk("midrst_quad", 32'(quad_mode), 32'h0);
        chk("midrst_oe", 32'(sio_oe), 32'h0);
        #19 rst = 1'b0;
        stop();
        expect_rd(8'h11, 0); expect_rd(8'h22, 0);
        start(); send(8'h03, 0, 8); send_addr(24'h0000FF, 0); read(2, 0); stop();

        #100;
        chk("rd_queue_left", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
